uart_tx_sched: RTL

//  Shares one UART transmit line (9600 baud, 8N1) between NUM_REQ byte producers on the 100 MHz clock.
//  - Round-robin arbiter grants one requester per frame.
//  - Internal baud-tick counter, restarted at each frame, times each bit.
//  - Frame serialiser drives tx.

---
 rtl/uart_tx_sched_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_tx_sched.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared FSM encodings and frame constants
// for the UART transmit scheduler.
package uart_tx_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 10416;
  localparam int FRAME_BITS_8N1       = 10;
  localparam int FRAME_BITS_8E1       = 11;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: per-bit timer, restarted at each frame grant.
// bit_tick marks the last clock of every bit period.
module uart_baud_tick
  import uart_tx_sched_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk_100,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = (cnt == LAST);

  // count 0..CLKS_PER_BIT-1, restart on grant or wrap
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin share of one UART TX line.
// Define UART_PARITY_EN for 8E1 frames; default is 8N1.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int NUM_REQ      = 2,
  parameter int DATA_W       = 8
) (
  input  logic                       clk_100,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BI_W = $clog2(DATA_W);
  localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_W - 1);

  state_t            state;
  state_t            state_nxt;
  logic              bit_tick;
  logic              grant;
  logic              found;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   rr_nxt;
  logic [DATA_W-1:0] win_data;
  logic [DATA_W-1:0] shreg;
  logic [BI_W-1:0]   bit_idx;
`ifdef UART_PARITY_EN
  logic              par;
`endif

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_100 (clk_100),
    .rst_n   (rst_n),
    .clear   (grant),
    .bit_tick(bit_tick)
  );

  // first valid at or above rr_ptr, then wrap to below it
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_data = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] &&
            ((p == 0) == (i >= int'(rr_ptr)))) begin
          found    = 1'b1;
          win      = ID_W'(i);
          win_data = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign grant  = (state == ST_IDLE) && found;
  assign rr_nxt = (win == ID_LAST) ? '0 : win + 1'b1;

  // state register
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // frame sequencing, advanced by bit_tick
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (grant) state_nxt = ST_START;
      ST_START: if (bit_tick) state_nxt = ST_DATA;
      ST_DATA: begin
        if (bit_tick && bit_idx == BI_LAST) begin
`ifdef UART_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: if (bit_tick) state_nxt = ST_STOP;
`endif
      ST_STOP:  if (bit_tick) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // line level, busy flag and accept pulse
  always_comb begin
    tx        = 1'b1;
    busy      = (state != ST_IDLE);
    req_ready = '0;
    case (state)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = shreg[0];
`ifdef UART_PARITY_EN
      ST_PARITY: tx = par;
`endif
      default:   tx = 1'b1;
    endcase
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant && (win == ID_W'(i));
    end
  end

  // latch granted byte, shift out LSB first, rotate pointer
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      bit_idx  <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
`ifdef UART_PARITY_EN
      par      <= 1'b0;
`endif
    end else if (grant) begin
      shreg    <= win_data;
      bit_idx  <= '0;
      grant_id <= win;
      rr_ptr   <= rr_nxt;
`ifdef UART_PARITY_EN
      par      <= ^win_data;
`endif
    end else if (bit_tick && state == ST_DATA) begin
      shreg    <= shreg >> 1;
      bit_idx  <= bit_idx + 1'b1;
    end
  end

endmodule
